// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, transmit FSM states and the default baud divisor.
package mmio_uart_tx_pkg;

  localparam logic [1:0] OFF_TXDATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS   = 2'd1;
  localparam logic [1:0] OFF_BAUDDIV  = 2'd2;
  localparam logic [1:0] OFF_RESERVED = 2'd3;

  localparam int STAT_SHIFTING = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_EMPTY    = 2;
  localparam int STAT_OVERFLOW = 3;
  localparam int STAT_CNT_LSB  = 4;
  localparam int STAT_CNT_MSB  = 8;

  localparam logic [15:0] BAUD_DIV_DEFAULT = 16'd434;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with combinational head read; a push into a full FIFO is
// accepted when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter answering MEM-stage loads/stores.
// state | meaning: IDLE line high | START start bit | DATA 8 bits LSB first | STOP stop bit
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h1001_0000,
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [15:0] BAUD_DIV_RESET = BAUD_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Selected,
  output logic        Tx,
  output logic        Busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    offset;
  logic          wr_txdata;
  logic          wr_status;
  logic          wr_baud;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_data;
  logic [CW-1:0] fifo_count;
  logic [15:0]   baud_div;
  logic [15:0]   eff_div;
  logic          overflow;
  logic [31:0]   status;
  uart_state_e   state;
  logic          tx_q;
  logic [15:0]   period;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          bit_done;
  logic          unused_bits;

  assign Selected  = (Address[31:4] == BASE_ADDR[31:4]);
  assign offset    = Address[3:2];
  assign wr_txdata = Selected && MemWrite && (offset == OFF_TXDATA);
  assign wr_status = Selected && MemWrite && (offset == OFF_STATUS);
  assign wr_baud   = Selected && MemWrite && (offset == OFF_BAUDDIV);
  assign unused_bits = ^{Address[1:0], WriteData[31:16]};

  assign eff_div  = (baud_div == 16'd0) ? 16'd1 : baud_div;
  assign bit_done = (baud_cnt == period - 16'd1);
  // A new frame starts from IDLE, or straight out of the last stop-bit cycle.
  assign pop = !fifo_empty && ((state == ST_IDLE) || ((state == ST_STOP) && bit_done));

  assign Tx   = tx_q;
  assign Busy = (state != ST_IDLE) || !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .pop   (pop),
    .wdata (WriteData[7:0]),
    .rdata (fifo_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_div <= BAUD_DIV_RESET;
      overflow <= 1'b0;
    end else begin
      if (wr_baud) baud_div <= WriteData[15:0];
      if (wr_txdata && fifo_full && !pop) overflow <= 1'b1;
      else if (wr_status && WriteData[STAT_OVERFLOW]) overflow <= 1'b0;
    end
  end

  always_comb begin
    status = '0;
    status[STAT_SHIFTING] = (state != ST_IDLE);
    status[STAT_FULL]     = fifo_full;
    status[STAT_EMPTY]    = fifo_empty;
    status[STAT_OVERFLOW] = overflow;
    status[STAT_CNT_MSB:STAT_CNT_LSB] = 5'(fifo_count);
  end

  always_comb begin
    ReadData = '0;
    if (Selected && MemRead) begin
      case (offset)
        OFF_STATUS:  ReadData = status;
        OFF_BAUDDIV: ReadData = {16'd0, baud_div};
        default:     ReadData = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      tx_q     <= 1'b1;
      period   <= 16'd0;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
    end else if (pop) begin
      state    <= ST_START;
      tx_q     <= 1'b0;
      period   <= eff_div;
      shift    <= fifo_data;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_q     <= 1'b1;
          baud_cnt <= 16'd0;
          bit_idx  <= 3'd0;
        end
        ST_START: begin
          if (bit_done) begin
            state    <= ST_DATA;
            tx_q     <= shift[0];
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            baud_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              state   <= ST_STOP;
              tx_q    <= 1'b1;
              bit_idx <= 3'd0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx_q    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            state    <= ST_IDLE;
            baud_cnt <= 16'd0;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random bus traffic, checked
// every cycle against a frame-level reference model of the transmitter.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Selected;
  logic        Tx;
  logic        Busy;

  mmio_uart_tx #(
    .BASE_ADDR      (BASE),
    .FIFO_DEPTH     (DEPTH),
    .BAUD_DIV_RESET (16'd434)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Selected  (Selected),
    .Tx        (Tx),
    .Busy      (Busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        tx_log   [0:19999];
  logic        busy_log [0:19999];
  logic [31:0] last_rd;

  // Reference model: pending bytes, the most recent frame and the register values.
  byte unsigned m_q[$];
  int           m_baud;
  bit           m_ovf;
  int           f_start;
  int           f_p;
  logic [7:0]   f_byte;
  int           line_free;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_q.delete();
    m_baud    = 434;
    m_ovf     = 1'b0;
    f_start   = -1000000;
    f_p       = 1;
    f_byte    = 8'h00;
    line_free = 0;
  endfunction

  function automatic bit m_in_frame(input int c);
    return (c >= f_start) && (c < f_start + 10 * f_p);
  endfunction

  function automatic logic m_tx(input int c);
    int b;
    if (!m_in_frame(c)) return 1'b1;
    b = (c - f_start) / f_p;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return f_byte[b-1];
  endfunction

  function automatic logic [31:0] m_status(input int c);
    logic [31:0] s;
    s    = '0;
    s[0] = m_in_frame(c);
    s[1] = (m_q.size() == DEPTH);
    s[2] = (m_q.size() == 0);
    s[3] = m_ovf;
    s[8:4] = 5'(m_q.size());
    return s;
  endfunction

  // One bus cycle: drive, compare outputs against the model, then advance the model over the edge.
  task automatic step(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    logic        sel;
    logic [31:0] exp_rd;
    bit          pop;
    int          sz;
    MemRead   = rd;
    MemWrite  = wr;
    Address   = addr;
    WriteData = data;
    #1;
    sel    = (addr[31:4] == BASE[31:4]);
    exp_rd = '0;
    if (sel && rd) begin
      case (addr[3:2])
        2'd1:    exp_rd = m_status(cyc);
        2'd2:    exp_rd = 32'(m_baud);
        default: exp_rd = '0;
      endcase
    end
    check("tx", Tx, m_tx(cyc));
    check("busy", Busy, (m_q.size() != 0) || m_in_frame(cyc));
    check("selected", Selected, sel);
    check("readdata", ReadData, exp_rd);
    tx_log[cyc]   = Tx;
    busy_log[cyc] = Busy;
    last_rd       = ReadData;
    sz  = m_q.size();
    pop = (sz != 0) && (cyc + 1 >= line_free);
    if (pop) begin
      f_start   = cyc + 1;
      f_p       = (m_baud == 0) ? 1 : m_baud;
      f_byte    = m_q.pop_front();
      line_free = f_start + 10 * f_p;
    end
    if (wr && sel) begin
      case (addr[3:2])
        2'd0: if (sz < DEPTH || pop) m_q.push_back(data[7:0]); else m_ovf = 1'b1;
        2'd1: if (data[3]) m_ovf = 1'b0;
        2'd2: m_baud = int'(data[15:0]);
        default: ;
      endcase
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      Address   = '0;
      WriteData = '0;
      #1;
      tx_log[cyc]   = Tx;
      busy_log[cyc] = Busy;
      @(negedge clk);
      cyc++;
    end
    reset = 1'b0;
    m_reset();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, BASE + 32'h4, 32'h0);
  endtask

  int          n_b, n_c, n_e, n_f;
  int          r;
  logic        rd, wr;
  logic [31:0] addr, data;

  initial begin
    reset     = 1'b1;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = '0;
    WriteData = '0;
    m_reset();
    @(negedge clk);
    do_reset(3);

    // Reset state
    step(1'b1, 1'b0, BASE + 32'h4, 32'h0);
    check("rst_status", last_rd, 32'h0000_0004);
    check("rst_tx", tx_log[cyc-1], 1'b1);
    step(1'b1, 1'b0, BASE + 32'h8, 32'h0);
    check("rst_bauddiv", last_rd, 32'd434);

    // Single frame 0x55 at P=4
    step(1'b0, 1'b1, BASE + 32'h8, 32'd4);
    n_b = cyc;
    step(1'b0, 1'b1, BASE, 32'h55);
    idle(45);
    check("b_idle_before", tx_log[n_b+1], 1'b1);
    check("b_start_first", tx_log[n_b+2], 1'b0);
    check("b_start_last", tx_log[n_b+5], 1'b0);
    check("b_bit0", tx_log[n_b+6], 1'b1);
    check("b_bit1", tx_log[n_b+10], 1'b0);
    check("b_stop", tx_log[n_b+38], 1'b1);
    check("b_busy_last", busy_log[n_b+41], 1'b1);
    check("b_busy_low", busy_log[n_b+42], 1'b0);

    // Overflow at P=1 with back-to-back frames
    step(1'b0, 1'b1, BASE + 32'h8, 32'd1);
    n_c = cyc;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, BASE, 32'($urandom_range(0, 255)));
    step(1'b1, 1'b0, BASE + 32'h4, 32'h0);
    check("c_status_ovf", last_rd, 32'h0000_004B);
    step(1'b0, 1'b1, BASE + 32'h4, 32'h8);
    step(1'b1, 1'b0, BASE + 32'h4, 32'h0);
    check("c_ovf_cleared", last_rd[3], 1'b0);
    idle(60);
    check("c_b2b_stop", tx_log[n_c+11], 1'b1);
    check("c_b2b_start", tx_log[n_c+12], 1'b0);

    // Access outside the window
    step(1'b1, 1'b1, BASE + 32'h40, 32'h77);
    check("d_outside_rd", last_rd, 32'h0);
    step(1'b1, 1'b0, BASE + 32'h4, 32'h0);
    check("d_count_same", last_rd, 32'h0000_0004);

    // BAUDDIV change mid-frame
    step(1'b0, 1'b1, BASE + 32'h8, 32'd2);
    n_e = cyc;
    step(1'b0, 1'b1, BASE, 32'hC3);
    step(1'b0, 1'b1, BASE, 32'h00);
    idle(3);
    step(1'b0, 1'b1, BASE + 32'h8, 32'd8);
    idle(110);
    check("e_f1_stop", tx_log[n_e+21], 1'b1);
    check("e_f2_start", tx_log[n_e+22], 1'b0);
    check("e_f2_bit7", tx_log[n_e+93], 1'b0);
    check("e_f2_stop", tx_log[n_e+101], 1'b1);
    check("e_busy_last", busy_log[n_e+101], 1'b1);
    check("e_busy_low", busy_log[n_e+102], 1'b0);

    // Reset during data bit 3
    step(1'b0, 1'b1, BASE + 32'h8, 32'd4);
    n_f = cyc;
    step(1'b0, 1'b1, BASE, 32'hA5);
    step(1'b0, 1'b1, BASE, 32'h11);
    step(1'b0, 1'b1, BASE, 32'h22);
    idle(n_f + 19 - cyc);
    do_reset(1);
    idle(60);
    check("f_bit3", tx_log[n_f+19], 1'b0);
    check("f_tx_after_rst", tx_log[n_f+20], 1'b1);
    check("f_status", last_rd, 32'h0000_0004);
    check("f_busy", busy_log[cyc-1], 1'b0);
    step(1'b1, 1'b0, BASE + 32'h8, 32'h0);
    check("f_bauddiv", last_rd, 32'd434);

    // Random traffic
    step(1'b0, 1'b1, BASE + 32'h8, 32'd2);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset(1);
        step(1'b0, 1'b1, BASE + 32'h8, 32'($urandom_range(1, 3)));
      end else begin
        r    = int'($urandom_range(0, 99));
        rd   = 1'($urandom_range(0, 1));
        wr   = 1'b1;
        data = $urandom();
        addr = BASE | 32'($urandom_range(0, 3));
        if (r < 15) begin
          addr = addr | 32'h0;
        end else if (r < 20) begin
          addr = addr | 32'h8;
          data = 32'($urandom_range(0, 3));
        end else if (r < 24) begin
          addr = addr | 32'h4;
        end else if (r < 27) begin
          addr = BASE ^ (32'h1 << $urandom_range(4, 31));
        end else if (r < 29) begin
          addr = addr | 32'hC;
        end else begin
          rd   = 1'b1;
          wr   = 1'b0;
          addr = addr | {28'h0, 2'($urandom_range(0, 3)), 2'b00};
        end
        step(rd, wr, addr, data);
      end
    end
    idle(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
